div_feeder: RTL and testbench

Operand queue and sequencer that sits directly upstream of the 4-bit sequential divider.
- Accepts dividend/divisor pairs on a valid/ready interface and buffers them in a small FIFO.
- Issues each pair to the divider with a one-cycle load pulse and waits out the divider's fixed latency.
- Captures the quotient and presents it downstream on a valid/ready interface.
- Handles divide-by-zero locally, without using the divider.

---
 rtl/div_feeder.sv | 122 ++++++++++++
 tb/tb_div_feeder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_feeder.sv
// Operand FIFO and sequencer in front of a fixed-latency 4-bit divider.
// Pairs are issued in push order; a zero divisor is answered locally with q=4'hF, dz=1.
module div_feeder #(
  parameter int DEPTH   = 4,
  parameter int DIV_LAT = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_a,
  input  logic [3:0]                   in_b,
  output logic                         div_ld,
  output logic [3:0]                   div_a,
  output logic [3:0]                   div_b,
  input  logic [3:0]                   div_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_q,
  output logic                         out_dz,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      head_a, head_b;
  logic            push, pop, head_dz;
  logic [LW-1:0]   lat_cnt;

  assign in_ready         = !rst && (count != CW'(DEPTH));
  assign push             = in_valid && in_ready;
  assign pop              = (state == IDLE) && (count != '0);
  assign {head_a, head_b} = mem[rd_ptr];
  assign head_dz          = (head_b == 4'd0);

  // NOTE: storage array has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_dz ? HOLD : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The divider quotient is valid only in the last cycle of the WAIT window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_ld    <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_dz    <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      div_ld <= pop && !head_dz;
      case (state)
        IDLE: begin
          if (pop) begin
            if (!head_dz) begin
              div_a <= head_a;
              div_b <= head_b;
            end else begin
              out_q     <= 4'hF;
              out_dz    <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        ISSUE: lat_cnt <= LW'(DIV_LAT - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            out_q     <= div_y;
            out_dz    <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        HOLD:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_feeder.sv
// Self-checking bench for div_feeder: directed table, multi-cycle corner sequences,
// and randomized traffic scored against a queue-based model of the expected results.
module tb_div_feeder;
  localparam int DEPTH   = 4;
  localparam int DIV_LAT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b;
  logic       div_ld;
  logic [3:0] div_a, div_b;
  logic [3:0] div_y = 4'd0;
  logic       out_valid, out_ready;
  logic [3:0] out_q;
  logic       out_dz;
  logic [2:0] count;

  div_feeder #(.DEPTH(DEPTH), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_ld(div_ld), .div_a(div_a), .div_b(div_b), .div_y(div_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_dz(out_dz),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] a; logic [3:0] b;} pair_t;
  typedef struct {logic [3:0] q; logic dz;} res_t;
  typedef struct {logic [3:0] a; logic [3:0] b; logic [3:0] q; logic dz;} vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    ld_count = 0;
  res_t  exp_q [$];
  pair_t iss_q [$];
  int    ld_cycs [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic res_t model_div(input logic [3:0] a, input logic [3:0] b);
    res_t r;
    if (b == 4'd0) begin r.q = 4'hF; r.dz = 1'b1; end
    else           begin r.q = a / b; r.dz = 1'b0; end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Divider model: quotient is presented only during cycle ld+DIV_LAT, its complement otherwise.
  logic [3:0] qa = 4'd0, qb = 4'd0;
  int         dctr = 99;
  always @(posedge clk) begin
    #1;
    if (rst) dctr = 99;
    else if (div_ld) begin qa = div_a; qb = div_b; dctr = 0; end
    else if (dctr < 99) dctr++;
    if (qb == 4'd0) div_y = 4'd0;
    else            div_y = (dctr == DIV_LAT) ? qa / qb : ~(qa / qb);
  end

  // Scoreboard: records accepted pairs, checks issued operands and every presented result.
  logic  prev_ld = 1'b0;
  pair_t mp;
  res_t  mr;
  always @(negedge clk) begin
    if (rst) prev_ld = 1'b0;
    else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model_div(in_a, in_b));
        if (in_b != 4'd0) iss_q.push_back('{in_a, in_b});
      end
      if (div_ld) begin
        ld_count++;
        ld_cycs.push_back(cyc);
        check("ld_in_hold", {31'd0, out_valid}, 0);
        check("ld_width", {31'd0, prev_ld}, 0);
        if (iss_q.size() == 0) check("spurious_ld", {31'd0, div_ld}, 0);
        else begin
          mp = iss_q.pop_front();
          check("div_a", {28'd0, div_a}, {28'd0, mp.a});
          check("div_b", {28'd0, div_b}, {28'd0, mp.b});
        end
      end
      prev_ld = div_ld;
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", {31'd0, out_valid}, 0);
        else begin
          mr = exp_q[0];
          check("out_q", {28'd0, out_q}, {28'd0, mr.q});
          check("out_dz", {31'd0, out_dz}, {31'd0, mr.dz});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("push_accept", {31'd0, ok}, 1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    check("drain", {31'd0, ok}, 1);
    check("issue_left", iss_q.size(), 0);
    out_ready = 1'b0;
  endtask

  task automatic apply_single(input vec_t v);
    int e, ld0;
    bit ok = 1'b0;
    @(posedge clk); #1;
    e = cyc; ld0 = ld_count; ld_cycs.delete();
    in_a = v.a; in_b = v.b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("valid_timeout", {31'd0, ok}, 1);
    check("latency", cyc - e, (v.b == 4'd0) ? 2 : DIV_LAT + 3);
    check("vec_q", {28'd0, out_q}, {28'd0, v.q});
    check("vec_dz", {31'd0, out_dz}, {31'd0, v.dz});
    if (v.b != 4'd0) check("ld_cycle", (ld_cycs.size() > 0) ? ld_cycs[0] : -1, e + 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 0);
    check("ld_pulses", ld_count - ld0, (v.b != 4'd0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   ld0, pushes_left;
    bit   ok, acc;

    tbl[0] = '{4'd13, 4'd4,  4'd3,  1'b0};
    tbl[1] = '{4'd7,  4'd0,  4'hF,  1'b1};
    tbl[2] = '{4'd15, 4'd1,  4'd15, 1'b0};
    tbl[3] = '{4'd0,  4'd5,  4'd0,  1'b0};
    tbl[4] = '{4'd15, 4'd15, 4'd1,  1'b0};
    tbl[5] = '{4'd9,  4'd0,  4'hF,  1'b1};
    tbl[6] = '{4'd11, 4'd2,  4'd5,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_count", {29'd0, count}, 0);
    check("rst_div_ld", {31'd0, div_ld}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_q", {28'd0, out_q}, 0);
    check("rst_out_dz", {31'd0, out_dz}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 1);

    for (int i = 0; i < 7; i++) apply_single(tbl[i]);

    // Fill the FIFO under backpressure; the sixth pair waits for the first result.
    out_ready = 1'b0;
    push_pair(4'd9, 4'd3);
    push_pair(4'd8, 4'd2);
    push_pair(4'd15, 4'd5);
    push_pair(4'd6, 4'd1);
    push_pair(4'd12, 4'd4);
    in_a = 4'd10; in_b = 4'd2; in_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    ld0 = ld_count;
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", {31'd0, out_valid}, 1);
      check("full_in_ready", {31'd0, in_ready}, 0);
      check("full_count", {29'd0, count}, 4);
      @(posedge clk); #1;
    end
    check("hold_no_ld", ld_count - ld0, 0);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sixth_accepted", {31'd0, ok}, 1);
    wait_drain();

    // Back-to-back nonzero pairs with a ready sink: one issue per DIV_LAT+3 cycles.
    out_ready = 1'b1;
    ld_cycs.delete();
    push_pair(4'd9, 4'd3);
    push_pair(4'd8, 4'd2);
    wait_drain();
    check("ld_count_tp", ld_cycs.size(), 2);
    if (ld_cycs.size() == 2) check("throughput", ld_cycs[1] - ld_cycs[0], DIV_LAT + 3);

    // Push and pop at the same edge with two pairs queued.
    out_ready = 1'b0;
    push_pair(4'd6, 4'd3);
    push_pair(4'd12, 4'd3);
    push_pair(4'd15, 4'd3);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("pp_valid", {31'd0, ok}, 1);
    check("pp_count_before", {29'd0, count}, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_a = 4'd5; in_b = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pp_count_after", {29'd0, count}, 2);
    wait_drain();

    // Asynchronous reset in the middle of WAIT with two pairs queued.
    out_ready = 1'b0;
    ld0 = ld_count;
    push_pair(4'd9, 4'd3);
    push_pair(4'd8, 4'd2);
    push_pair(4'd15, 4'd5);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ld_count > ld0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_seq_ld", {31'd0, ok}, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_div_ld", {31'd0, div_ld}, 0);
    check("arst_div_a", {28'd0, div_a}, 0);
    check("arst_div_b", {28'd0, div_b}, 0);
    check("arst_out_valid", {31'd0, out_valid}, 0);
    check("arst_out_q", {28'd0, out_q}, 0);
    check("arst_out_dz", {31'd0, out_dz}, 0);
    check("arst_count", {29'd0, count}, 0);
    check("arst_in_ready", {31'd0, in_ready}, 0);
    exp_q.delete();
    iss_q.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ld0 = ld_count;
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_valid", {31'd0, out_valid}, 0);
    check("no_stale_ld", ld_count - ld0, 0);
    check("post_rst_count", {29'd0, count}, 0);
    apply_single('{4'd14, 4'd7, 4'd2, 1'b0});

    // Randomized traffic with random backpressure; many pointer wraps.
    pushes_left = 10 * DEPTH;
    in_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (pushes_left == 0 && !in_valid) break;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        if (pushes_left > 0 && $urandom_range(0, 2) != 0) begin
          in_valid = 1'b1;
          in_a = 4'($urandom);
          in_b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
          pushes_left--;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("random_pushes_done", pushes_left, 0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
